param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (legal 2..32).
REQ-002 Parameter RESET_VAL, default 0, value loaded into count on reset (must be <= 2^WIDTH-1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 sat  input  1  boundary mode: 0 = wrap, 1 = saturate.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value for load.
REQ-010 max_val  input  WIDTH  run-time modulus ceiling; count range is 0..max_val.
REQ-011 clr_ovf  input  1  clears the sticky ovf flag.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 ovf  output  1  registered sticky flag, set on any wrap or saturation hit.

Function
REQ-015 Update priority per edge SHALL be: rst > load > en; with none active, count holds and tc = 0.
REQ-016 Load SHALL set count = min(load_val, max_val), force tc = 0, and leave ovf unchanged.
REQ-017 An enabled up step with count < max_val SHALL set count = count+1 and tc = 0.
REQ-018 An enabled up step with count >= max_val SHALL: wrap mode -> count = 0, tc = 1, ovf = 1; saturate mode -> count = max_val, tc = 1, ovf = 1.
REQ-019 An enabled down step with count > 0 and count <= max_val SHALL set count = count-1 and tc = 0.
REQ-020 An enabled down step with count = 0 SHALL: wrap mode -> count = max_val, tc = 1, ovf = 1; saturate mode -> count = 0, tc = 1, ovf = 1.
REQ-021 An enabled down step with count > max_val (max_val lowered mid-run) SHALL set count = max_val, tc = 0, with ovf unchanged.
REQ-022 tc SHALL be high exactly in the cycle following the boundary edge, and SHALL re-pulse on each enabled step held at a saturation boundary.
REQ-023 max_val = 0 SHALL be legal: count stays 0 and every enabled step produces tc = 1.
REQ-024 Arithmetic SHALL be unsigned modulo 2^WIDTH internally, and count SHALL never leave 0..2^WIDTH-1.
REQ-025 ovf SHALL clear when clr_ovf = 1 unless a new ovf-setting event occurs on the same edge; in that case set wins.
REQ-026 up, sat, and max_val SHALL be sampled every edge and may change on any cycle without glitching outputs.

Reset
REQ-027 On an edge with rst = 1, the block SHALL set count = RESET_VAL, tc = 0, and ovf = 0, regardless of all other inputs.
REQ-028 Reset asserted mid-count or mid-load SHALL take effect on that edge, and counting SHALL resume on the first edge after rst deasserts.
REQ-029 Before the first reset edge, output values are undefined, and the bench SHALL NOT check them.

Verification (WIDTH = 4, RESET_VAL = 0 unless stated)
REQ-030 rst = 1 for 2 edges with en = 1, load = 1 -> count = 0, tc = 0, ovf = 0.
REQ-031 max_val = 15, up = 1, sat = 0, en = 1 for 16 edges -> count 1..15 then 0, tc = 1 only after the 16th edge, ovf = 1.
REQ-032 max_val = 9, up = 1, wrap mode, 20 edges -> decade sequence 0..9 repeating, tc pulses after edges 10 and 20.
REQ-033 sat = 1, load 4'd2, up = 0, en = 1 for 4 edges -> count 1, 0, 0, 0, tc = 1 after edges 3 and 4; then clr_ovf = 1 -> ovf = 0.
REQ-034 max_val = 9, load with load_val = 4'd13 -> count = 9; the same edge with en = 1 confirms load wins and tc = 0.
REQ-035 count = 12, max_val lowered to 5: up step -> count = 0, tc = 1; separately, down step from 12 -> count = 5, tc = 0.

Source files
------------

// File: rtl/param_updown_counter.sv
// param_updown_counter: up/down counter with run-time ceiling, wrap/saturate modes, tc pulse and sticky ovf
module param_updown_counter #(
  parameter int unsigned            WIDTH     = 4,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d, ovf_q, ovf_d;
  logic             at_top, at_bot, above, hit;
  assign at_top = count_q >= max_val;
  assign at_bot = count_q == '0;
  assign above  = count_q > max_val;
  always_comb begin
    count_d = count_q;
    hit     = 1'b0;
    if (load) count_d = load_val > max_val ? max_val : load_val;
    else if (en && up) begin
      hit     = at_top;
      count_d = at_top ? (sat ? max_val : '0) : count_q + ONE;
    end else if (en) begin
      hit     = at_bot;
      // a ceiling lowered below the count snaps back without flagging overflow
      count_d = at_bot ? (sat ? '0 : max_val) : above ? max_val : count_q - ONE;
    end
    tc_d  = hit;
    ovf_d = hit | (ovf_q & ~clr_ovf);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end
  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed self-checking bench for param_updown_counter (WIDTH=4, RESET_VAL=0)
module tb_param_updown_counter;
  logic       clk = 1'b0;
  logic       rst, en, up, sat, load, clr_ovf;
  logic [3:0] load_val, max_val, count;
  logic       tc, ovf;
  int         n_chk = 0;
  int         n_err = 0;
  param_updown_counter #(.WIDTH(4), .RESET_VAL(4'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
    .count(count), .tc(tc), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic all3(input string tag, input int c, input int t, input int o);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".tc"}, 32'(tc), 32'(t));
    chk({tag, ".ovf"}, 32'(ovf), 32'(o));
  endtask
  initial begin
    rst = 1; en = 1; up = 1; sat = 0; load = 1; load_val = 4'd7; max_val = 4'd15; clr_ovf = 0;
    step(); step();
    all3("reset", 0, 0, 0);
    rst = 0; load = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("wrap16.count%0d", i), 32'(count), 32'(i % 16));
      chk($sformatf("wrap16.tc%0d", i), 32'(tc), 32'(i == 16));
    end
    chk("wrap16.ovf", 32'(ovf), 32'd1);
    en = 0; clr_ovf = 1;
    step();
    all3("hold_clr", 0, 0, 0);
    clr_ovf = 0; en = 1; max_val = 4'd9;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("decade.count%0d", i), 32'(count), 32'(i % 10));
      chk($sformatf("decade.tc%0d", i), 32'(tc), 32'(i % 10 == 0));
    end
    en = 0; clr_ovf = 1;
    step();
    chk("decade.clr", 32'(ovf), 32'd0);
    clr_ovf = 0; load = 1; load_val = 4'd9;
    step();
    load = 0; en = 1; clr_ovf = 1;
    step();
    all3("set_wins", 0, 1, 1);
    clr_ovf = 0; en = 0; sat = 1; load = 1; load_val = 4'd2;
    step();
    all3("sat_load", 2, 0, 1);
    load = 0; up = 0; en = 1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("satdn.count%0d", i), 32'(count), 32'(i < 2 ? 1 : 0));
      chk($sformatf("satdn.tc%0d", i), 32'(tc), 32'(i >= 3));
    end
    en = 0; clr_ovf = 1;
    step();
    all3("satdn_clr", 0, 0, 0);
    clr_ovf = 0; load = 1; load_val = 4'd9;
    step();
    load = 0; up = 1; en = 1;
    step();
    all3("satup1", 9, 1, 1);
    step();
    all3("satup2", 9, 1, 1);
    en = 0; clr_ovf = 1; sat = 0;
    step();
    clr_ovf = 0; load = 1; load_val = 4'd13; en = 1; up = 1;
    step();
    all3("load_clamp", 9, 0, 0);
    max_val = 4'd15; load_val = 4'd12;
    step();
    load = 0; max_val = 4'd5; up = 1;
    step();
    all3("lower_up", 0, 1, 1);
    load = 1; max_val = 4'd15; clr_ovf = 1;
    step();
    all3("reload12", 12, 0, 0);
    load = 0; clr_ovf = 0; max_val = 4'd5; up = 0;
    step();
    all3("lower_dn", 5, 0, 0);
    en = 0;
    step();
    all3("hold", 5, 0, 0);
    max_val = 4'd0; en = 1; up = 1;
    step();
    all3("max0_up", 0, 1, 1);
    up = 0;
    step();
    all3("max0_dn", 0, 1, 1);
    max_val = 4'd9; up = 1; load = 1; load_val = 4'd3;
    step();
    load = 0;
    step();
    chk("pre_rst", 32'(count), 32'd4);
    rst = 1; load = 1;
    step();
    all3("mid_rst", 0, 0, 0);
    rst = 0; load = 0;
    step();
    all3("resume", 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
